hazard_stall_ctrl: RTL

// - Stall/bubble controller for the 5-stage LC-3b pipeline; the stalling counterpart of the EX-stage forwarding mux selects.
// - Detects load-use hazards that forwarding cannot cover and inserts exactly one ID/EX bubble.
// - Freezes the whole pipe while instruction or data memory is outstanding.
// - Sequences the two data accesses of LDI/STI: pointer access first, then the data access.

---
 rtl/lc3b_types.sv | 13 +
 rtl/hazard_perf_counter.sv | 21 ++
 rtl/hazard_stall_ctrl.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/lc3b_types.sv
// Shared LC-3b pipeline types used by the hazard/stall controller.
//   lc3b_reg           - 3-bit architectural register index (r0..r7)
//   lc3b_hazard_state  - memory-phase FSM state of the stall controller
package lc3b_types;

    typedef logic [2:0] lc3b_reg;

    typedef enum logic {
        HZ_RUN,
        HZ_IND
    } lc3b_hazard_state;

endpackage

// File: rtl/hazard_perf_counter.sv
// One 16-bit saturating event counter.
//   clk    in   pipeline clock
//   rst    in   asynchronous active-high clear
//   inc    in   count one event this cycle
//   count  out  current count; holds at 16'hFFFF
module hazard_perf_counter (
    input  logic        clk,
    input  logic        rst,
    input  logic        inc,
    output logic [15:0] count
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 16'd1;
        end
    end

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Stall/bubble controller for the 5-stage LC-3b pipeline.
// - Inserts one ID/EX bubble on a load-use hazard forwarding cannot cover.
// - Freezes the whole pipe while instruction or data memory is outstanding.
// - Sequences LDI/STI: pointer access (mem_phase=0) then data access (mem_phase=1).
// Optional: define HAZARD_PERF_CNT_EN to add three 16-bit saturating
// performance counters and their output ports.
// Ports:
//   clk, rst                          clock, async active-high reset
//   id_sr1/id_sr2/id_dest (+ _used)   ID-stage source operands
//   ex_dest, ex_regwrite, ex_is_load  EX-stage producer info
//   imem_req/imem_resp                fetch handshake
//   dmem_req/dmem_indirect/dmem_resp  MEM-stage data handshake
//   pc_load .. mem_wb_load            pipeline register enables
//   id_ex_bubble                      load NOP into ID/EX
//   mem_phase                         0 = pointer/only access, 1 = indirect data
//   ptr_latch                         MEM captures pointer read data this cycle
//   perf_*_cnt                        freeze / bubble / indirect counts (optional)
module hazard_stall_ctrl
    import lc3b_types::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  id_sr1,
    input  logic [2:0]  id_sr2,
    input  logic [2:0]  id_dest,
    input  logic        id_sr1_used,
    input  logic        id_sr2_used,
    input  logic        id_dest_used,
    input  logic [2:0]  ex_dest,
    input  logic        ex_regwrite,
    input  logic        ex_is_load,
    input  logic        imem_req,
    input  logic        imem_resp,
    input  logic        dmem_req,
    input  logic        dmem_indirect,
    input  logic        dmem_resp,
    output logic        pc_load,
    output logic        if_id_load,
    output logic        id_ex_load,
    output logic        id_ex_bubble,
    output logic        ex_mem_load,
    output logic        mem_wb_load,
    output logic        mem_phase,
    output logic        ptr_latch
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [15:0] perf_freeze_cnt,
    output logic [15:0] perf_bubble_cnt,
    output logic [15:0] perf_ind_cnt
`endif
);

    lc3b_hazard_state state, state_next;
    logic             lu_hazard;
    logic             dmem_done;
    logic             freeze;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= HZ_RUN;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next   = state;
        pc_load      = 1'b1;
        if_id_load   = 1'b1;
        id_ex_load   = 1'b1;
        id_ex_bubble = 1'b0;
        ex_mem_load  = 1'b1;
        mem_wb_load  = 1'b1;
        mem_phase    = (state == HZ_IND);
        ptr_latch    = 1'b0;

        // r0 is an ordinary register in LC-3b, so indices compare literally.
        lu_hazard = ex_is_load && ex_regwrite &&
                    ((id_sr1_used  && (id_sr1  == ex_dest)) ||
                     (id_sr2_used  && (id_sr2  == ex_dest)) ||
                     (id_dest_used && (id_dest == ex_dest)));

        // An indirect op only completes on its second (data) response.
        dmem_done = dmem_req && dmem_resp && (!dmem_indirect || (state == HZ_IND));
        freeze    = (imem_req && !imem_resp) || (dmem_req && !dmem_done);

        case (state)
            HZ_RUN: begin
                if (dmem_req && dmem_indirect && dmem_resp) begin
                    state_next = HZ_IND;
                    ptr_latch  = 1'b1;
                end
            end
            HZ_IND: begin
                if (dmem_resp) begin
                    state_next = HZ_RUN;
                end
            end
            default: state_next = HZ_RUN;
        endcase

        // While reset is held the pipe is forced to its free-running state.
        if (rst) begin
            ptr_latch = 1'b0;
        end else if (freeze) begin
            pc_load     = 1'b0;
            if_id_load  = 1'b0;
            id_ex_load  = 1'b0;
            ex_mem_load = 1'b0;
            mem_wb_load = 1'b0;
        end else if (lu_hazard) begin
            pc_load      = 1'b0;
            if_id_load   = 1'b0;
            id_ex_bubble = 1'b1;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    hazard_perf_counter u_freeze_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (freeze),
        .count (perf_freeze_cnt)
    );

    hazard_perf_counter u_bubble_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (id_ex_bubble),
        .count (perf_bubble_cnt)
    );

    hazard_perf_counter u_ind_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (ptr_latch),
        .count (perf_ind_cnt)
    );
`endif

endmodule
